// File: rtl/wisc_pkg.sv
// Shared WISC definitions: ALU opcodes, branch condition codes, flag bit
// positions and the branch-redirect FSM state type.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_UN = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against {N,V,Z} flags.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [2:0] i_flags,
    output logic       o_taken
);

    logic w_n, w_v, w_z;

    assign w_n = i_flags[FLAG_N];
    assign w_v = i_flags[FLAG_V];
    assign w_z = i_flags[FLAG_Z];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_NE: o_taken = ~w_z;
            COND_EQ: o_taken = w_z;
            COND_GT: o_taken = ~w_z & ~w_n;
            COND_LT: o_taken = w_n;
            COND_GE: o_taken = ~w_n | w_z;
            COND_LE: o_taken = w_n | w_z;
            COND_OV: o_taken = w_v;
            COND_UN: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with per-opcode write masks, EX->ID flag
// forwarding, and a two-state FSM issuing a registered PC redirect/squash.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int unsigned AW  = 16,
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_alu_op,
    input  logic [2:0]     alu_flags,
    input  logic           br_valid,
    input  logic [2:0]     br_cond,
    input  logic [AW-1:0]  br_target,
    output logic [2:0]     flags_q,
    output logic           redirect,
    output logic [AW-1:0]  redirect_pc,
    output logic           squash
);

    logic [2:0]    r_flags;
    logic          r_redirect;
    logic          r_squash;
    logic [AW-1:0] r_redirect_pc;
    br_state_t     r_state;

    logic [2:0]    w_wr_mask;
    logic [2:0]    w_eff_flags;
    logic          w_taken;

    always_comb begin
        w_wr_mask = '0;
        if (ex_valid && !stall) begin
            case (ex_alu_op)
                OP_ADD, OP_SUB: w_wr_mask = 3'b111;
                OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:
                    w_wr_mask = 3'b001 << FLAG_Z;
                default: w_wr_mask = '0;
            endcase
        end
    end

    // The forwarded value is exactly what the register captures this edge.
    assign w_eff_flags = (w_wr_mask & alu_flags) | (~w_wr_mask & r_flags);

    branch_cond_eval u_cond (
        .i_cond  (br_cond),
        .i_flags (w_eff_flags),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags       <= '0;
            r_redirect    <= 1'b0;
            r_squash      <= 1'b0;
            r_redirect_pc <= '0;
            r_state       <= IDLE;
        end else if (!stall) begin
            r_flags <= w_eff_flags;
            case (r_state)
                IDLE: begin
                    if (br_valid && w_taken) begin
                        r_state       <= REDIRECT;
                        r_redirect    <= 1'b1;
                        r_squash      <= 1'b1;
                        r_redirect_pc <= br_target;
                    end else begin
                        r_redirect    <= 1'b0;
                        r_squash      <= 1'b0;
                        r_redirect_pc <= '0;
                    end
                end
                REDIRECT: begin
                    // Branch in ID now is on the wrong path and is dropped.
                    r_state       <= IDLE;
                    r_redirect    <= 1'b0;
                    r_squash      <= 1'b0;
                    r_redirect_pc <= '0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_redirect    <= 1'b0;
                    r_squash      <= 1'b0;
                    r_redirect_pc <= '0;
                end
            endcase
        end
    end

    assign flags_q     = r_flags;
    assign redirect    = r_redirect;
    assign squash      = r_squash;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed, table-driven bench for flag_branch_unit.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [2:0]  alu_flags;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic [2:0]  flags_q;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        squash;

    int total = 0;
    int bad   = 0;

    flag_branch_unit #(.AW(16), .OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_alu_op   (ex_alu_op),
        .alu_flags   (alu_flags),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_target   (br_target),
        .flags_q     (flags_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .squash      (squash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ex_valid;
        logic [3:0] op;
        logic [2:0] alu;
        logic [2:0] exp_flags;
    } flag_vec_t;

    typedef struct {
        logic [2:0] cond;
        logic [2:0] flags;
        logic       exp_taken;
    } cond_vec_t;

    flag_vec_t fvec [12];
    cond_vec_t cvec [64];
    logic [7:0] truth [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; ex_valid = 1'b0; ex_alu_op = 4'h0; alu_flags = 3'b000;
        br_valid = 1'b0; br_cond = 3'b000; br_target = 16'h0000;
    endtask

    initial begin
        // Flag update sequence starting from 000 after reset.
        fvec[0]  = '{1'b1, 4'b0000, 3'b101, 3'b101}; // ADD
        fvec[1]  = '{1'b1, 4'b0011, 3'b000, 3'b100}; // AND: Z only
        fvec[2]  = '{1'b1, 4'b1011, 3'b111, 3'b100}; // LLB: none
        fvec[3]  = '{1'b1, 4'b0010, 3'b010, 3'b010}; // SUB
        fvec[4]  = '{1'b1, 4'b0100, 3'b001, 3'b011}; // NOR
        fvec[5]  = '{1'b1, 4'b0111, 3'b100, 3'b010}; // SRA
        fvec[6]  = '{1'b1, 4'b0001, 3'b111, 3'b010}; // PADDSB
        fvec[7]  = '{1'b1, 4'b0101, 3'b111, 3'b011}; // SLL
        fvec[8]  = '{1'b1, 4'b0110, 3'b000, 3'b010}; // SRL
        fvec[9]  = '{1'b1, 4'b1000, 3'b101, 3'b010}; // LW
        fvec[10] = '{1'b1, 4'b1111, 3'b101, 3'b010}; // undefined
        fvec[11] = '{1'b0, 4'b0000, 3'b111, 3'b010}; // ADD, not valid

        // Taken truth per condition, bit index = {N,V,Z}.
        truth[0] = 8'h55; truth[1] = 8'hAA; truth[2] = 8'h05; truth[3] = 8'hF0;
        truth[4] = 8'hAF; truth[5] = 8'hFA; truth[6] = 8'hCC; truth[7] = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cvec[c*8+f].cond      = 3'(c);
                cvec[c*8+f].flags     = 3'(f);
                cvec[c*8+f].exp_taken = truth[c][f];
            end
        end

        // 1: reset dominates random inputs
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            stall = 1'($urandom); ex_valid = 1'($urandom); ex_alu_op = 4'($urandom);
            alu_flags = 3'($urandom); br_valid = 1'($urandom); br_cond = 3'($urandom);
            br_target = 16'($urandom);
            tick();
            check("rst_flags", 32'(flags_q), 32'h0);
            check("rst_redirect", 32'(redirect), 32'h0);
            check("rst_squash", 32'(squash), 32'h0);
            check("rst_pc", 32'(redirect_pc), 32'h0);
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        check("post_rst_flags", 32'(flags_q), 32'h0);

        // 2: flag write masks
        for (int i = 0; i < 12; i++) begin
            ex_valid = fvec[i].ex_valid; ex_alu_op = fvec[i].op; alu_flags = fvec[i].alu;
            tick();
            check($sformatf("flags_vec%0d", i), 32'(flags_q), 32'(fvec[i].exp_flags));
            check($sformatf("flags_noredir%0d", i), 32'(redirect), 32'h0);
        end
        // Stall freezes flags
        stall = 1'b1; ex_valid = 1'b1; ex_alu_op = 4'b0000; alu_flags = 3'b111;
        tick();
        check("stall_flags", 32'(flags_q), 32'h2);
        idle_inputs();

        // 3: forwarded Z from SUB into EQ branch (flags_q Z=0 beforehand)
        ex_valid = 1'b1; ex_alu_op = 4'b0010; alu_flags = 3'b001;
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0040;
        tick();
        check("fwd_redirect", 32'(redirect), 32'h1);
        check("fwd_squash", 32'(squash), 32'h1);
        check("fwd_pc", 32'(redirect_pc), 32'h0040);
        check("fwd_flags", 32'(flags_q), 32'h1);
        idle_inputs();
        tick();
        check("fwd_one_cycle", 32'(redirect), 32'h0);

        // 4: wrong-path branch during REDIRECT ignored
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h1234;
        tick();
        check("un_redirect", 32'(redirect), 32'h1);
        check("un_pc", 32'(redirect_pc), 32'h1234);
        br_target = 16'h5678;
        tick();
        check("wrongpath_ignored", 32'(redirect), 32'h0);
        idle_inputs();
        tick();
        check("wrongpath_none", 32'(redirect), 32'h0);

        // 5: stall with pending GT branch, then stall held in REDIRECT
        ex_valid = 1'b1; ex_alu_op = 4'b0000; alu_flags = 3'b000;
        tick();
        check("gt_setup_flags", 32'(flags_q), 32'h0);
        idle_inputs();
        stall = 1'b1; br_valid = 1'b1; br_cond = 3'b010; br_target = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("stall_noredir%0d", i), 32'(redirect), 32'h0);
        end
        stall = 1'b0;
        tick();
        check("gt_redirect", 32'(redirect), 32'h1);
        check("gt_pc", 32'(redirect_pc), 32'hBEEF);
        stall = 1'b1; br_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("stall_hold%0d", i), 32'(redirect), 32'h1);
            check($sformatf("stall_hold_sq%0d", i), 32'(squash), 32'h1);
        end
        idle_inputs();
        tick();
        check("stall_release", 32'(redirect), 32'h0);

        // 6: every condition against every flag value
        for (int i = 0; i < 64; i++) begin
            ex_valid = 1'b1; ex_alu_op = 4'b0000; alu_flags = cvec[i].flags;
            br_valid = 1'b0;
            tick();
            ex_valid = 1'b0;
            br_valid = 1'b1; br_cond = cvec[i].cond; br_target = 16'(16'hA000 + i);
            tick();
            check($sformatf("cond%0d_f%0d", cvec[i].cond, cvec[i].flags),
                  32'(redirect), 32'(cvec[i].exp_taken));
            if (cvec[i].exp_taken)
                check($sformatf("cond_pc%0d", i), 32'(redirect_pc), 32'(16'hA000 + i));
            br_valid = 1'b0;
            tick();
            check($sformatf("cond_clear%0d", i), 32'(redirect), 32'h0);
        end

        // Reset during REDIRECT
        idle_inputs();
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h7777;
        tick();
        check("pre_rst_redirect", 32'(redirect), 32'h1);
        rst = 1'b1; br_valid = 1'b0;
        tick();
        check("mid_rst_redirect", 32'(redirect), 32'h0);
        check("mid_rst_pc", 32'(redirect_pc), 32'h0);
        check("mid_rst_squash", 32'(squash), 32'h0);
        rst = 1'b0;
        tick();
        check("after_rst_redirect", 32'(redirect), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
